// File: rtl/alu_mc.sv
// alu_mc: small multi-cycle ALU. Seven operations complete in a single cycle.
// Unsigned MUL uses a W-step shift-add and completes at the W-th edge after it is accepted.
// Ports: clk, reset (async, active-high) | start/Ain/Bin/ALUop request, sampled only
//        when ready=1 | out/status{V,N,Z} registered result, done = 1-cycle update pulse.
module alu_mc #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] Ain,
  input  logic [W-1:0] Bin,
  input  logic [2:0]   ALUop,
  output logic         ready,
  output logic [W-1:0] out,
  output logic [2:0]   status,
  output logic         done
);

  localparam int SW = $clog2(W);      // ASR shift-amount width
  localparam int CW = $clog2(W + 1);  // iteration counter must hold the value W

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ASR = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state, state_nxt;
  logic [2*W-1:0]   mcand;      // multiplicand, shifted left one place per step
  logic [2*W-1:0]   acc;        // partial product
  logic [2*W-1:0]   acc_nxt;
  logic [W-1:0]     mplier;     // multiplier, shifted right so bit 0 is the current bit
  logic [CW-1:0]    cnt;
  logic             accept_op;  // single-cycle op accepted this edge
  logic             accept_mul; // MUL accepted this edge
  logic             mul_last;   // this edge performs the final shift-add step
  logic [SW-1:0]    shamt;
  logic [W-1:0]     alu_res;
  logic             alu_v;
  logic [W-1:0]     res;
  logic             res_v;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and control strobes
  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    accept_op  = 1'b0;
    accept_mul = 1'b0;
    mul_last   = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (ALUop == OP_MUL) begin
            accept_mul = 1'b1;
            state_nxt  = S_MUL;
          end else begin
            accept_op = 1'b1;
          end
        end
      end
      S_MUL: begin
        // start is ignored here; ready stays low until the completion edge
        if (cnt == CW'(1)) begin
          mul_last  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle operations, evaluated directly on the live inputs
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    shamt   = Bin[SW-1:0];
    case (ALUop)
      OP_ADD: begin
        alu_res = Ain + Bin;
        alu_v   = (Ain[W-1] == Bin[W-1]) && (alu_res[W-1] != Ain[W-1]);
      end
      OP_SUB: begin
        alu_res = Ain - Bin;
        alu_v   = (Ain[W-1] != Bin[W-1]) && (alu_res[W-1] != Ain[W-1]);
      end
      OP_AND:  alu_res = Ain & Bin;
      OP_NOT:  alu_res = ~Bin;
      OP_OR:   alu_res = Ain | Bin;
      OP_XOR:  alu_res = Ain ^ Bin;
      // A shift of W or more (non-power-of-two W) still saturates to the sign bit.
      OP_ASR:  alu_res = $signed(Ain) >>> shamt;
      default: alu_res = '0;  // MUL goes through the iterative path
    endcase
  end

  // One shift-add step; on the last step this sum is the full 2W product.
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    if (mul_last) begin
      res   = acc_nxt[W-1:0];
      res_v = |acc_nxt[2*W-1:W];
    end else begin
      res   = alu_res;
      res_v = alu_v;
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      out    <= '0;
      status <= 3'b000;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_mul) begin
        // Operands are latched here so later input changes cannot disturb the MUL.
        mcand  <= {{W{1'b0}}, Ain};
        mplier <= Bin;
        acc    <= '0;
        cnt    <= CW'(W);
      end else if (state == S_MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end
      if (accept_op || mul_last) begin
        out    <= res;
        status <= {res_v, res[W-1], (res == '0)};
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: W, 16, operand/result width in bits; legal range 4..64.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request; sampled only at a rising edge where ready=1.
REQ-005 Port: Ain  input  W  operand A; captured with start.
REQ-006 Port: Bin  input  W  operand B; captured with start.
REQ-007 Port: ALUop  input  3  operation select; captured with start.
REQ-008 Port: ready  output  1  block can accept start this cycle.
REQ-009 Port: out  output  W  registered result; holds until next completion.
REQ-010 Port: status  output  3  registered flags {V,N,Z}, bit2=V, bit1=N, bit0=Z.
REQ-011 Port: done  output  1  one-cycle pulse marking that out/status were just updated.

Function
REQ-012 ALUop encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 NOT Bin, 100 OR, 101 XOR, 110 MUL (unsigned, low W bits), 111 ASR (Ain arithmetic right shift by Bin[clog2(W)-1:0]).
REQ-013 ADD/SUB SHALL be modulo 2^W; no carry output.
REQ-014 FSM SHALL have states IDLE and MUL only.
REQ-015 IDLE: ready=1; start with ALUop!=110 SHALL register out/status and assert done at that same edge (latency 1 cycle), staying in IDLE.
REQ-016 IDLE: start with ALUop=110 SHALL capture operands, clear a 2W accumulator, load iteration counter with W, go to MUL; done not asserted that cycle.
REQ-017 MUL: ready=0; each edge SHALL perform one shift-add step (add shifted A if current multiplier bit set) and decrement the counter.
REQ-018 MUL SHALL complete at the W-th edge after acceptance: out=product[W-1:0], status updated, done=1 for that cycle, return to IDLE.
REQ-019 start while ready=0 SHALL be ignored with no effect on state, operands or outputs.
REQ-020 During done cycle ready=1; a start then SHALL be accepted (back-to-back, no bubble).
REQ-021 Z SHALL equal (new out == 0); N SHALL equal new out[W-1].
REQ-022 V SHALL be signed overflow for ADD (operands same sign, result sign differs) and SUB (operands differ in sign, result sign differs from Ain); for MUL V=1 iff product[2W-1:W]!=0; V=0 for all other ops.
REQ-023 ASR shift amount >= W-1 SHALL yield all bits equal to Ain[W-1].
REQ-024 Operand changes on Ain/Bin/ALUop after acceptance SHALL NOT affect an in-flight MUL.
REQ-025 done SHALL never be asserted on two consecutive cycles without an accepted start between completions.

Reset
REQ-026 reset=1 SHALL immediately (without clk) force state IDLE, out=0, status=3'b000, done=0, ready=1, counter and accumulator=0.
REQ-027 reset asserted mid-MUL SHALL abort the operation; no done pulse SHALL follow for the aborted operation.
REQ-028 First start SHALL be accepted at the first rising edge after reset deasserts.

Verification (W=16)
REQ-029 ADD Ain=0x7FFF, Bin=0x0001 -> next edge out=0x8000, status=3'b110, done=1 one cycle.
REQ-030 SUB Ain=0x0005, Bin=0x0005 -> out=0x0000, status=3'b001; then NOT Bin=0x0000 back-to-back in done cycle -> out=0xFFFF, status=3'b010.
REQ-031 MUL Ain=300, Bin=300 -> ready=0 for 16 cycles, done at 16th edge after acceptance, out=0x5F90, status=3'b100.
REQ-032 During that MUL, pulse start with ADD 1+1 at cycle 5 -> ignored; MUL result unchanged, no extra done.
REQ-033 Start MUL 0x00FF*0x00FF, assert reset at cycle 8 -> out=0, status=0, ready=1 immediately, no done afterward; next ADD 2+3 -> out=0x0005.
REQ-034 ASR Ain=0x8000, Bin=0x0003 -> out=0xF000, status=3'b010; Bin=0x000F -> out=0xFFFF.
